// File: rtl/pc_next_reg.sv
// Program-counter register and next-PC sequencer with stall-time redirect buffering and halt/resume.
// Optional build macro PC_ALIGN_CHK_EN traps misaligned redirect targets to EXC_PC.
module pc_next_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        halted_q;
  logic        pend_vld_q;
  logic [31:0] pend_tgt_q;

  logic        live_vld;
  logic [31:0] live_tgt;
  logic        redir_vld;
  logic [31:0] redir_tgt;

  always_comb begin
    live_vld = jr | jump | branch_taken;
    live_tgt = branch_target;
    if (jr)        live_tgt = jr_target;
    else if (jump) live_tgt = jump_target;
  end

  // A live redirect on the release cycle overrides whatever was buffered during the stall.
  assign redir_vld = live_vld | pend_vld_q;
  assign redir_tgt = live_vld ? live_tgt : pend_tgt_q;

`ifdef PC_ALIGN_CHK_EN
  logic        misalign_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
      epc_q      <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      if (state_q == RUN && !stall && redir_vld && redir_tgt[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
        epc_q      <= redir_tgt;
      end
    end
  end

  assign misalign = misalign_q;
  assign epc      = epc_q;
`else
  assign misalign = 1'b0;
  assign epc      = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            if (live_vld) begin
              pend_vld_q <= 1'b1;
              pend_tgt_q <= live_tgt;
            end
          end else begin
            pend_vld_q <= 1'b0;
            if (redir_vld) begin
`ifdef PC_ALIGN_CHK_EN
              if (redir_tgt[1:0] != 2'b00) pc_q <= EXC_PC;
              else                         pc_q <= redir_tgt;
`else
              pc_q <= {redir_tgt[31:2], 2'b00};
`endif
            end else begin
              pc_q <= pc_plus4;
            end
            if (halt_req) begin
              state_q    <= HALT;
              pc_valid_q <= 1'b0;
              halted_q   <= 1'b1;
            end
          end
        end
        HALT: begin
          // The pending buffer survives HALT and is consumed after resume.
          if (resume) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;

endmodule

// File: doc/pc_next_reg.md
# pc_next_reg

Program-counter register and next-PC sequencer for the single-cycle MIPS datapath. Each cycle it holds the current `pc`, which drives the PC incrementer. It takes back that incrementer's `pc_plus4` and chooses the next PC from sequential, branch, jump or register-jump targets. It also handles stall, redirect buffering during stall, and halt/resume.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into `pc` on reset.
- `EXC_PC`, default 32'h0000_0080: exception vector. Used only with `PC_ALIGN_CHK_EN`.
- `clk`  in  1  rising-edge clock. This block uses one clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `pc_plus4`  in  32  PC+4 from the incrementer, computed from `pc`.
- `branch_taken`  in  1  take `branch_target`.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  take `jump_target` (j/jal).
- `jump_target`  in  32  jump destination.
- `jr`  in  1  take `jr_target` (jr/jalr).
- `jr_target`  in  32  register-jump destination.
- `stall`  in  1  hold `pc` this cycle.
- `halt_req`  in  1  request entry to HALT.
- `resume`  in  1  leave HALT.
- `pc`  out  32  current PC. Registered.
- `pc_valid`  out  1  `pc` holds a fetchable address.
- `halted`  out  1  block is in HALT.
- `misalign`  out  1  one-cycle pulse when a misaligned target is trapped.
- `epc`  out  32  offending target from the last trap.

## Operation
- Redirect priority: `jr` > `jump` > `branch_taken` > `pc_plus4`. The selected value is `nxt`.
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset. `pc_valid`=0 and `pc` holds. Moves to RUN after one cycle unconditionally.
  - RUN, `stall`=0: `pc`<=`nxt`.
  - RUN, `stall`=1: `pc` holds.
  - RUN, `stall`=0 and `halt_req`=1: `pc`<=`nxt`, then go to HALT.
  - HALT: `pc` holds, `halted`=1, `pc_valid`=0. All redirects are ignored. `resume`=1 moves to RUN next cycle. `halt_req` is ignored while in HALT.
- Pending-redirect buffer (`pend_vld`, `pend_tgt`):
  - In RUN with `stall`=1, any asserted redirect is captured into the buffer. The highest-priority redirect wins. A later capture while still stalled overwrites the buffer.
  - On the first cycle with `stall`=0: a live redirect in that cycle overrides the buffer. Otherwise `pc`<=`pend_tgt`. The buffer clears either way.
  - If the buffer is still set when the block enters HALT, it is kept and applied on the first non-stalled RUN cycle after `resume`.
- `halt_req` with `stall`=1 is ignored. The requester must hold `halt_req` until stall drops.
- Arithmetic: all addresses are 32 bits, modulo 2^32. `pc`=32'hFFFF_FFFC with sequential flow wraps `pc` to 0.

## Timing
- `pc` updates only on the rising edge of `clk`. Redirect-to-`pc` latency is one cycle; zero bubbles when there is no stall.
- Reset values: `pc`=`RESET_PC`, `pc_valid`=0, `halted`=0, `misalign`=0, `epc`=0, pending buffer cleared, state BOOT.
- Asserting `rst` in any state takes effect immediately, without waiting for a clock edge. Any pending redirect is discarded.
- `pc_valid`=1 exactly when the state is RUN.
- `halted` is registered and asserts the cycle after the HALT transition edge.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - If the chosen redirect target (live or pending) has bits [1:0]≠0, then `pc`<=`EXC_PC`, `epc`<=that target, and `misalign` pulses for one cycle.
  - Sequential flow is never checked.
- `PC_ALIGN_CHK_EN` undefined:
  - All targets have bits [1:0] forced to 0.
  - `misalign` is tied to 0 and `epc` is tied to 0.
  - `EXC_PC` is unused.

## Test plan
- Reset to sequential run: release `rst` → `pc`=0 and `pc_valid`=0 for one cycle, then `pc` = 0, 4, 8, 12 on successive edges.
- Redirect priority: at `pc`=0x10, assert `jr`(0x400), `jump`(0x200) and `branch_taken`(0x100) together → next `pc`=0x400.
- Stall buffering: at `pc`=0x20, assert `stall` for 3 cycles with `branch_taken`(0x80) pulsed in cycle 1 only → `pc`=0x20 throughout the stall, then 0x80, then 0x84.
- Halt/resume: `halt_req` at `pc`=0x40 → `pc`=0x44 and `halted`=1. `jump` while halted has no effect. `resume` → `pc_valid`=1, then `pc`=0x48.
- Wrap and async reset:
  - From `pc`=0xFFFF_FFFC → `pc`=0.
  - Assert `rst` between clock edges while RUN with a pending redirect held → `pc`=`RESET_PC` immediately and the buffer is lost.
- Alignment (with `PC_ALIGN_CHK_EN`):
  - `jr_target`=0x102 → `pc`=0x80, `epc`=0x102, `misalign` high for one cycle.
  - Without the macro, the same stimulus gives `pc`=0x100.
